// File: rtl/mcu_sequencer_pkg.sv
// Shared opcode, state and instruction-field definitions for the mcu_sequencer slice.
// Pure declarations: no latency, no backpressure.
package mcu_sequencer_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 6;
  localparam int TGT_MSB = 5;
  localparam int TGT_LSB = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    ERROR  = 3'd7
  } state_t;

  typedef struct packed {
    logic reg_dst;
    logic alu_src;
    logic mem_to_reg;
    logic is_mem;
    logic is_store;
    logic is_jump;
  } ctrl_t;

endpackage

// File: rtl/mcu_sequencer_if.sv
// Instruction-fetch, data-memory and datapath-control bundle between the sequencer and its environment.
// Wires only; Mem_Req/Mem_Ack is a level request held until a one-cycle ack.
interface mcu_sequencer_if;
  logic       Start;
  logic [7:0] Read_Address;
  logic [7:0] Instruction;
  logic [7:0] Instr_Reg;
  logic       Mem_Req;
  logic       Mem_Write;
  logic       Mem_Ack;
  logic       Reg_Write;
  logic       Reg_Dst;
  logic       ALU_Src;
  logic       Mem_to_Reg;
  logic       Busy;
  logic       Halted;
  logic       Error;

  modport master (
    input  Start, Instruction, Mem_Ack,
    output Read_Address, Instr_Reg, Mem_Req, Mem_Write, Reg_Write,
           Reg_Dst, ALU_Src, Mem_to_Reg, Busy, Halted, Error
  );

  modport slave (
    output Start, Instruction, Mem_Ack,
    input  Read_Address, Instr_Reg, Mem_Req, Mem_Write, Reg_Write,
           Reg_Dst, ALU_Src, Mem_to_Reg, Busy, Halted, Error
  );
endinterface

// File: rtl/mcu_decode.sv
// Opcode to datapath mux-control and instruction-class map.
// Purely combinational, zero latency, no backpressure.
module mcu_decode
  import mcu_sequencer_pkg::*;
(
  input  logic [1:0] op,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (op)
      OP_ADD: ctrl.reg_dst = 1'b1;
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.is_mem     = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src  = 1'b1;
        ctrl.is_mem   = 1'b1;
        ctrl.is_store = 1'b1;
      end
      default: ctrl.is_jump = 1'b1;
    endcase
  end

endmodule

// File: rtl/mcu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC and IR for the 8-bit core.
// add 4, j 3, sw 4+N, lw 5+N cycles; stalls in MEM on Mem_Ack up to MEM_TIMEOUT cycles.
module mcu_sequencer
  import mcu_sequencer_pkg::*;
#(
  parameter int PROG_LEN    = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mcu_sequencer_if.master       bus
);

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ctrl_vld;
  ctrl_t      ctrl;

  mcu_decode u_decode (
    .op   (ir_q[OP_MSB:OP_LSB]),
    .ctrl (ctrl)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, HALT, ERROR: begin
        if (bus.Start) begin
          state_d = FETCH;
          pc_d    = '0;
        end
      end
      FETCH: begin
        if (int'(pc_q) >= PROG_LEN) begin
          state_d = HALT;
        end else begin
          ir_d    = bus.Instruction;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        if (ctrl.is_jump) begin
          pc_d    = {pc_q[7:6], ir_q[TGT_MSB:TGT_LSB]};
          state_d = FETCH;
        end else if (ctrl.is_mem) begin
          cnt_d   = '0;
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        // An ack in the same cycle as the final wait still completes the access.
        if (bus.Mem_Ack) begin
          if (ctrl.is_store) begin
            pc_d    = pc_q + 8'd1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(MEM_TIMEOUT - 1)) begin
            state_d = ERROR;
          end
        end
      end
      WB: begin
        pc_d    = pc_q + 8'd1;
        state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from the state register so reset drops them asynchronously.
  always_comb begin
    ctrl_vld         = (state_q == DECODE) || (state_q == EXEC) ||
                       (state_q == MEM)    || (state_q == WB);
    bus.Read_Address = pc_q;
    bus.Instr_Reg    = ir_q;
    bus.Mem_Req      = (state_q == MEM);
    bus.Mem_Write    = (state_q == MEM) && ctrl.is_store;
    bus.Reg_Write    = (state_q == WB);
    bus.Reg_Dst      = ctrl_vld && ctrl.reg_dst;
    bus.ALU_Src      = ctrl_vld && ctrl.alu_src;
    bus.Mem_to_Reg   = ctrl_vld && ctrl.mem_to_reg;
    bus.Busy         = !((state_q == IDLE) || (state_q == HALT) || (state_q == ERROR));
    bus.Halted       = (state_q == HALT);
    bus.Error        = (state_q == ERROR);
  end

endmodule

// File: tb/tb_mcu_sequencer.sv
// Self-checking bench for mcu_sequencer: instruction-level reference model, directed plan items, random programs.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mcu_sequencer;
  import mcu_sequencer_pkg::*;

  localparam int PROG_LEN    = 5;
  localparam int MEM_TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] imem [256];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: architectural PC plus stopped/faulted flags only.
  logic [7:0] m_pc = 8'd0;
  bit         m_halted = 1'b0;
  bit         m_error  = 1'b0;

  mcu_sequencer_if bus ();
  mcu_sequencer_if bus3 ();

  mcu_sequencer #(.PROG_LEN(PROG_LEN), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  mcu_sequencer #(.PROG_LEN(3), .MEM_TIMEOUT(MEM_TIMEOUT)) dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus3)
  );

  assign bus.Instruction  = imem[bus.Read_Address];
  assign bus3.Instruction = imem[bus3.Read_Address];

  always #5 clk = ~clk;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $display("FAIL %s at %0t: observed=0x%02h expected=0x%02h", tag, $time, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $display("FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, exp_v);
    end
  endtask

  task automatic expect_cycle(input string tag, input logic [7:0] addr, input logic busy,
                              input logic req, input logic wr, input logic regw,
                              input logic halted, input logic err);
    chk8({tag, ".addr"},   bus.Read_Address, addr);
    chk1({tag, ".busy"},   bus.Busy,         busy);
    chk1({tag, ".req"},    bus.Mem_Req,      req);
    chk1({tag, ".wr"},     bus.Mem_Write,    wr);
    chk1({tag, ".regw"},   bus.Reg_Write,    regw);
    chk1({tag, ".halted"}, bus.Halted,       halted);
    chk1({tag, ".error"},  bus.Error,        err);
  endtask

  // One instruction from its FETCH up to the next FETCH. n_wait >= MEM_TIMEOUT means no ack.
  task automatic run_instr(input int n_wait, input bit start_mid);
    logic [7:0] ins;
    logic [1:0] op;
    bit         is_mem, timeout, writes, in_mem;
    int         nmem, lat;
    if (int'(m_pc) >= PROG_LEN) begin
      bus.Start   = ($urandom_range(3) == 0);
      bus.Mem_Ack = ($urandom_range(1) == 0);
      expect_cycle("halt_fetch", m_pc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      bus.Start   = 1'b0;
      bus.Mem_Ack = 1'b0;
      m_halted    = 1'b1;
      return;
    end
    ins     = imem[m_pc];
    op      = ins[7:6];
    is_mem  = (op == OP_LW) || (op == OP_SW);
    timeout = is_mem && (n_wait >= MEM_TIMEOUT);
    nmem    = !is_mem ? 0 : (timeout ? MEM_TIMEOUT : n_wait + 1);
    writes  = (op == OP_ADD) || ((op == OP_LW) && !timeout);
    lat     = 3 + nmem + (writes ? 1 : 0);
    for (int k = 0; k < lat; k++) begin
      in_mem      = (k >= 3) && (k < 3 + nmem);
      bus.Start   = start_mid ? (k == 1) : ($urandom_range(7) == 0);
      bus.Mem_Ack = in_mem ? (!timeout && (k == 3 + n_wait)) : ($urandom_range(3) == 0);
      expect_cycle("instr", m_pc, 1'b1, in_mem, in_mem && (op == OP_SW),
                   writes && (k == lat - 1), 1'b0, 1'b0);
      if (k >= 1) begin
        chk8("instr.ir",         bus.Instr_Reg,  ins);
        chk1("instr.reg_dst",    bus.Reg_Dst,    op == OP_ADD);
        chk1("instr.alu_src",    bus.ALU_Src,    is_mem);
        chk1("instr.mem_to_reg", bus.Mem_to_Reg, op == OP_LW);
      end
      @(negedge clk);
    end
    bus.Start   = 1'b0;
    bus.Mem_Ack = 1'b0;
    if (timeout)         m_error = 1'b1;
    else if (op == OP_J) m_pc = {m_pc[7:6], ins[5:0]};
    else                 m_pc = m_pc + 8'd1;
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      bus.Start   = 1'b0;
      bus.Mem_Ack = ($urandom_range(1) == 0);
      expect_cycle(tag, m_pc, 1'b0, 1'b0, 1'b0, 1'b0, m_halted, m_error);
      @(negedge clk);
    end
    bus.Mem_Ack = 1'b0;
  endtask

  task automatic do_start();
    bus.Start   = 1'b1;
    bus.Mem_Ack = ($urandom_range(1) == 0);
    @(negedge clk);
    bus.Start   = 1'b0;
    bus.Mem_Ack = 1'b0;
    m_pc        = 8'd0;
    m_halted    = 1'b0;
    m_error     = 1'b0;
  endtask

  task automatic do_reset();
    bus.Start   = 1'b0;
    bus.Mem_Ack = 1'b0;
    bus3.Start  = 1'b0;
    reset_n     = 1'b0;
    @(negedge clk);
    reset_n  = 1'b1;
    m_pc     = 8'd0;
    m_halted = 1'b0;
    m_error  = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    int         nw;
    bus.Start    = 1'b0;
    bus.Mem_Ack  = 1'b0;
    bus3.Start   = 1'b0;
    bus3.Mem_Ack = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 8'($urandom);

    // Reset state of both instances.
    @(negedge clk);
    expect_cycle("reset", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk8("reset.ir",         bus.Instr_Reg,  8'd0);
    chk1("reset.reg_dst",    bus.Reg_Dst,    1'b0);
    chk1("reset.alu_src",    bus.ALU_Src,    1'b0);
    chk1("reset.mem_to_reg", bus.Mem_to_Reg, 1'b0);
    chk8("reset3.addr",      bus3.Read_Address, 8'd0);
    chk1("reset3.busy",      bus3.Busy,      1'b0);
    reset_n = 1'b1;
    idle_cycles("idle", 3);

    // Short program on the PROG_LEN=3 instance: three adds, then halt at PC=3.
    imem[0] = 8'h01; imem[1] = 8'h16; imem[2] = 8'h2B;
    bus3.Start = 1'b1;
    @(negedge clk);
    bus3.Start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk8("halt3.addr",   bus3.Read_Address, (k < 12) ? 8'(k / 4) : 8'd3);
      chk1("halt3.busy",   bus3.Busy,      k <= 12);
      chk1("halt3.halted", bus3.Halted,    k > 12);
      chk1("halt3.regw",   bus3.Reg_Write, (k < 12) && (k % 4 == 3));
      @(negedge clk);
    end
    bus3.Start = 1'b1;
    @(negedge clk);
    bus3.Start = 1'b0;
    chk8("restart3.addr",   bus3.Read_Address, 8'd0);
    chk1("restart3.busy",   bus3.Busy,   1'b1);
    chk1("restart3.halted", bus3.Halted, 1'b0);
    chk1("halt3.main_idle", bus.Busy,    1'b0);

    // Reference program with a jump back to 3; Start pulsed while executing byte 2.
    imem[0] = 8'h44; imem[1] = 8'h49; imem[2] = 8'h18; imem[3] = 8'h89; imem[4] = 8'hC3;
    do_start();
    for (int i = 0; i < 9; i++) run_instr(2, i == 2);
    chk8("loop.pc", m_pc, 8'd3);

    // Asynchronous reset while the store is waiting in MEM.
    for (int k = 0; k < 3; k++) @(negedge clk);
    chk1("rst_mem.req_before", bus.Mem_Req, 1'b1);
    reset_n = 1'b0;
    #1;
    chk1("rst_mem.req",  bus.Mem_Req,      1'b0);
    chk1("rst_mem.busy", bus.Busy,         1'b0);
    chk8("rst_mem.addr", bus.Read_Address, 8'd0);
    chk8("rst_mem.ir",   bus.Instr_Reg,    8'd0);
    @(negedge clk);
    reset_n  = 1'b1;
    m_pc     = 8'd0;
    m_halted = 1'b0;
    m_error  = 1'b0;
    idle_cycles("rst_mem.idle", 4);

    // lw with no ack times out; restart, then ack on the last allowed wait cycle.
    do_start();
    run_instr(MEM_TIMEOUT, 1'b0);
    idle_cycles("timeout", 3);
    do_start();
    run_instr(MEM_TIMEOUT - 1, 1'b0);
    chk8("late_ack.pc", m_pc, 8'd1);

    // Random programs and ack latencies, restarting after halt or error.
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < PROG_LEN; i++) begin
        b = 8'($urandom);
        if (b[7:6] == OP_J && $urandom_range(1) == 1) b[5:0] = 6'($urandom_range(0, 4));
        imem[i] = b;
      end
      do_reset();
      idle_cycles("rand.idle", 1);
      do_start();
      for (int i = 0; i < 30; i++) begin
        if (m_halted || m_error) begin
          idle_cycles("rand.stop", 2);
          do_start();
        end else begin
          nw = ($urandom_range(9) == 0) ? MEM_TIMEOUT : int'($urandom_range(0, MEM_TIMEOUT - 1));
          run_instr(nw, 1'b0);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
